mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's load/store path. It accepts one word request at a time from the CPU over a valid/ready request channel, waits a fixed number of wait states, and then performs the write or returns read data over a valid/ready response channel. It sits between the CPU's data-memory port and a word-organised RAM array, so memory latency is modelled explicitly rather than as a zero-delay combinational access.

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder and its RAM array.
package mem_resp_pkg;

  // Transaction phases of the responder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned MAX_WAIT   = 15;
  localparam int unsigned CNT_WIDTH  = 4;

endpackage

// File: rtl/mem_array.sv
// Word-organised RAM: one port, byte-masked synchronous write, registered read.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      wmask,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Masked write or registered read; rdata holds its value while idle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request, waits WAIT_CYCLES,
// then performs the access and holds the response until it is taken.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam logic [CNT_WIDTH-1:0] WaitInit = CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      wmask_q;
  logic                  err_q;
  logic                  rd_ok_q;

  logic                  accept;
  logic                  go_resp;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [WORD_WIDTH-1:0] acc_wdata;
  logic [LANES-1:0]      acc_wmask;
  logic                  acc_err;
  logic [WORD_WIDTH-1:0] mem_rdata;

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the access happens on the accepting edge, so the
  // array must see the live request; otherwise it sees the latched copy.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
  end

  assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == CntOne));
  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, loaded only on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Response status captured on entry to RESP, cleared on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (go_resp) begin
      err_q   <= acc_err;
      rd_ok_q <= !acc_err && !acc_write;
    end else if ((state_q == RESP) && resp_ready) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk  (clk),
    .en   (go_resp && !acc_err),
    .we   (acc_write),
    .addr (acc_addr[ADDR_WIDTH+1:2]),
    .wdata(acc_wdata),
    .wmask(acc_wmask),
    .rdata(mem_rdata)
  );

  // The array has no reset, so read data is gated by a reset-cleared flag.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, reset corner cases, randomized
// traffic against a word-array model, and a zero-wait-state instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wmask;

  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
  logic [3:0]  z_req_wmask;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .req_wmask(z_req_wmask), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  int checks = 0;
  int failures = 0;

  bit [31:0] ref_mem [1024];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    int          hold;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: 1024-word memory, addresses must be word aligned and below 4 KiB.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output logic [31:0] er, output logic ee);
    int idx;
    ee = (a % 4 != 0) || (a >= 32'd4096);
    er = 32'd0;
    if (!ee) begin
      idx = int'(a / 4);
      if (w) begin
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        er = ref_mem[idx];
      end
    end
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // One full transaction on the 2-wait-state instance with `hold` cycles of backpressure.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input int hold, input logic [31:0] er,
                     input logic ee, input string name);
    int lat;
    logic seen, stable;
    logic [31:0] r0;
    logic e0;
    @(negedge clk);
    chk({name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    resp_ready = 1'b0;
    @(posedge clk);
    // Scramble the request fields while the transaction is in flight.
    #1 req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    req_wmask = 4'($urandom);
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    chk({name, " latency"}, lat, 32'd3);
    if (!seen) return;
    chk({name, " rdata"}, resp_rdata, er);
    chk({name, " err"}, {31'd0, resp_err}, {31'd0, ee});
    r0 = resp_rdata;
    e0 = resp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable &= resp_valid && (resp_rdata === r0) && (resp_err === e0) && !req_ready;
    end
    if (hold > 0) chk({name, " stable under backpressure"}, {31'd0, stable}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({name, " ready after handshake"}, {30'd0, req_ready, resp_valid}, 32'd2);
  endtask

  // Reset asserted while a response is held; outputs must clear without a clock edge.
  task automatic reset_in_resp(input logic [31:0] a, input logic [31:0] er, input logic ee,
                               input string name);
    logic seen;
    start_req(1'b0, a, 32'd0, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, " resp before reset"}, {resp_err, resp_rdata[30:0], seen},
        {ee, er[30:0], 1'b1});
    reset = 1'b1;
    #1;
    chk({name, " async reset outputs"}, resp_rdata, 32'd0);
    chk({name, " async reset flags"}, {29'd0, req_ready, resp_valid, resp_err}, 32'd4);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic z_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = a; z_req_wdata = d;
    z_req_wmask = 4'hF; z_resp_ready = 1'b1;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    chk("z store resp after one edge", {30'd0, z_resp_valid, z_resp_err}, 32'd2);
    @(negedge clk);
    chk("z store ready again", {31'd0, z_req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er, exp_z, other_z, a, d;
    logic        ee, w, quiet;
    logic [3:0]  m;
    logic [7:0]  pattern;
    int          kind;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 5, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,   32'h55555555, 4'h0, 1, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,        4'hF, 0, 32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h00,   32'h11111111, 4'hF, 0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h20,   32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h13,   32'h0,        4'hF, 2, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h1000, 32'h99999999, 4'hF, 0, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h00,   32'h0,        4'hF, 0, 32'h11111111, 1'b0};
    vecs[11] = '{1'b0, 32'h20,   32'h0,        4'hF, 0, 32'hCAFEF00D, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_req_wmask = '0; z_resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset req_ready/resp_valid/err", {29'd0, req_ready, resp_valid, resp_err}, 32'd4);
    chk("reset rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      model_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, er, ee);
      txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].hold, vecs[i].er, vecs[i].ee,
          $sformatf("vec%0d", i));
    end

    // Store dropped by reset during its wait states.
    start_req(1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset in WAIT flags", {29'd0, req_ready, resp_valid, resp_err}, 32'd4);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      quiet &= !resp_valid;
    end
    chk("dropped store never responds", {31'd0, quiet}, 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1'b0, "load after dropped store");

    reset_in_resp(32'h10, 32'hDEADBEAA, 1'b0, "reset in RESP load");
    reset_in_resp(32'h13, 32'h0, 1'b1, "reset in RESP err");

    // Give the randomized region known contents.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model_txn(1'b1, 32'(i * 4), d, 4'hF, er, ee);
      txn(1'b1, 32'(i * 4), d, 4'hF, 0, er, ee, $sformatf("init%0d", i));
    end

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15) * 4);
      if (kind == 7) a = a + 32'($urandom_range(1, 3));
      else if (kind >= 8) a = $urandom | 32'h1000;
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      model_txn(w, a, d, m, er, ee);
      txn(w, a, d, m, int'($urandom_range(0, 3)), er, ee, $sformatf("rand%0d", i));
    end

    // Zero-wait-state instance: back-to-back loads with the address toggled in RESP.
    z_store(32'h0, 32'hA5A50001);
    z_store(32'h4, 32'h5A5A0002);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h0; z_resp_ready = 1'b1;
    exp_z = 32'hA5A50001;
    other_z = 32'hA5A50001;
    pattern = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pattern[k-1] = z_resp_valid;
      if (z_resp_valid) begin
        chk($sformatf("z load%0d rdata", k), z_resp_rdata, exp_z);
        z_req_addr = (z_req_addr == 32'h0) ? 32'h4 : 32'h0;
        #1;
        chk($sformatf("z load%0d rdata after addr toggle", k), z_resp_rdata, exp_z);
        other_z = exp_z;
        exp_z = (other_z == 32'hA5A50001) ? 32'h5A5A0002 : 32'hA5A50001;
      end
    end
    z_req_valid = 1'b0;
    chk("z back-to-back valid pattern", {24'd0, pattern}, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
